// File: rtl/axi_wdata_byte_serializer.sv
// Serializes one strobed AXI write-data word into its enabled bytes, LSB first,
// with a flush shared with the upstream spill register.
module axi_wdata_byte_serializer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] strb_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [7:0]          data_o,
  output logic                last_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    bytes_sent_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, SEND} state_e;

  logic [DATA_W-1:0] word_q, word_d;
  logic [STRB_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STRB_W-1:0] low_bit;
  logic [7:0]        byte_sel;
  logic              single_left;
  logic              byte_hs;
  logic              word_acc;
  state_e            state;

  // The machine state is implied by the remaining mask: SEND while any lane is left.
  assign state       = (mask_q != '0) ? SEND : IDLE;
  assign low_bit     = mask_q & (~mask_q + STRB_W'(1));
  assign single_left = (mask_q & (mask_q - STRB_W'(1))) == '0;

  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < STRB_W; k++) begin
      if (low_bit[k]) byte_sel = word_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  // A new word load overrides the clear of the last lane, enabling back-to-back words.
  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (byte_hs) begin
      mask_d = mask_q & ~low_bit;
      cnt_d  = cnt_q + CNT_W'(1);
    end
    if (flush_i) begin
      mask_d = '0;
    end else if (word_acc) begin
      word_d = data_i;
      mask_d = strb_i;
    end
  end

  always_comb begin
    busy_o       = (state == SEND);
    valid_o      = busy_o;
    data_o       = busy_o ? byte_sel : 8'h00;
    last_o       = busy_o && single_left;
    byte_hs      = valid_o && ready_i;
    ready_o      = !flush_i && (!busy_o || (byte_hs && last_o));
    word_acc     = valid_i && ready_o;
    bytes_sent_o = cnt_q;
  end

endmodule

// File: tb/tb_axi_wdata_byte_serializer.sv
// Directed self-checking bench for axi_wdata_byte_serializer (DATA_W=32, plus a CNT_W=4 copy for wrap).
module tb_axi_wdata_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_in;
  logic [3:0]  strb;
  logic        valid_out;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        last;
  logic        busy;
  logic [15:0] bytes_sent;

  logic        valid4_in;
  logic        ready4_out;
  logic [31:0] data4_in;
  logic [3:0]  strb4;
  logic        valid4_out;
  logic        ready4_in;
  logic [7:0]  data4_out;
  logic        last4;
  logic        busy4;
  logic [3:0]  bytes4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_wdata_byte_serializer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
    .data_i(data_in), .strb_i(strb), .valid_o(valid_out), .ready_i(ready_in),
    .data_o(data_out), .last_o(last), .busy_o(busy), .bytes_sent_o(bytes_sent)
  );

  axi_wdata_byte_serializer #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .valid_i(valid4_in), .ready_o(ready4_out),
    .data_i(data4_in), .strb_i(strb4), .valid_o(valid4_out), .ready_i(ready4_in),
    .data_o(data4_out), .last_o(last4), .busy_o(busy4), .bytes_sent_o(bytes4)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = '0; strb = '0; ready_in = 1'b1;
    valid4_in = 1'b0; data4_in = '0; strb4 = '0; ready4_in = 1'b1;
    #3;
    n_checks++;
    if ({valid_out, data_out, last, busy, bytes_sent, ready_out} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h l=%b b=%b cnt=%0d r=%b, expected 0 00 0 0 0 1",
               valid_out, data_out, last, busy, bytes_sent, ready_out);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_full_word();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    valid_in = 1'b1; data_in = 32'h44332211; strb = 4'hF; ready_in = 1'b1;
    #1;
    n_checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_accept: got ready=%b valid=%b, expected 1 0", ready_out, valid_out);
    end
    tick();
    valid_in = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== exp[k] || last !== (k == 3)) begin
        n_fail++;
        $display("[TB] FAIL full_byte%0d: got v=%b d=%h l=%b, expected 1 %h %b",
                 k, valid_out, data_out, last, exp[k], (k == 3));
      end
      tick();
    end
    n_checks++;
    if (valid_out !== 1'b0 || bytes_sent !== 16'd4) begin
      n_fail++;
      $display("[TB] FAIL full_done: got v=%b cnt=%0d, expected 0 4", valid_out, bytes_sent);
    end
  endtask

  task automatic test_sparse_and_zero();
    logic [7:0] exp [2] = '{8'hBB, 8'hDD};
    valid_in = 1'b1; data_in = 32'hDDCCBBAA; strb = 4'b1010;
    tick();
    valid_in = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== exp[k] || last !== (k == 1)) begin
        n_fail++;
        $display("[TB] FAIL sparse_byte%0d: got v=%b d=%h l=%b, expected 1 %h %b",
                 k, valid_out, data_out, last, exp[k], (k == 1));
      end
      tick();
    end
    valid_in = 1'b1; data_in = 32'hCAFEF00D; strb = 4'b0000;
    #1;
    n_checks++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL zero_accept: got ready=%b, expected 1", ready_out);
    end
    tick();
    valid_in = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0 || bytes_sent !== 16'd6) begin
      n_fail++;
      $display("[TB] FAIL zero_drop: got v=%b r=%b b=%b cnt=%0d, expected 0 1 0 6",
               valid_out, ready_out, busy, bytes_sent);
    end
  endtask

  task automatic test_back_to_back();
    valid_in = 1'b1; data_in = 32'h04030201; strb = 4'hF;
    tick();
    data_in = 32'h08070605;
    for (int k = 0; k < 8; k++) begin
      valid_in = (k < 4);
      #1;
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 8'(k + 1) || ready_out !== (k == 3 || k == 7)) begin
        n_fail++;
        $display("[TB] FAIL b2b_byte%0d: got v=%b d=%h r=%b, expected 1 %h %b",
                 k, valid_out, data_out, ready_out, 8'(k + 1), (k == 3 || k == 7));
      end
      tick();
    end
    valid_in = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || bytes_sent !== 16'd14) begin
      n_fail++;
      $display("[TB] FAIL b2b_done: got v=%b cnt=%0d, expected 0 14", valid_out, bytes_sent);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3] = '{8'hA2, 8'hA3, 8'hA4};
    valid_in = 1'b1; data_in = 32'hA4A3A2A1; strb = 4'hF;
    tick();
    valid_in = 1'b0;
    tick();
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 8'hA2 || last !== 1'b0 ||
          bytes_sent !== 16'd15 || ready_out !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall%0d: got v=%b d=%h l=%b cnt=%0d r=%b, expected 1 a2 0 15 0",
                 k, valid_out, data_out, last, bytes_sent, ready_out);
      end
      tick();
    end
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== exp[k] || last !== (k == 2)) begin
        n_fail++;
        $display("[TB] FAIL resume_byte%0d: got v=%b d=%h l=%b, expected 1 %h %b",
                 k, valid_out, data_out, last, exp[k], (k == 2));
      end
      tick();
    end
    n_checks++;
    if (bytes_sent !== 16'd18) begin
      n_fail++;
      $display("[TB] FAIL stall_count: got %0d, expected 18", bytes_sent);
    end
  endtask

  task automatic test_flush();
    valid_in = 1'b1; data_in = 32'hB4B3B2B1; strb = 4'hF;
    tick();
    valid_in = 1'b0;
    tick();
    flush = 1'b1; ready_in = 1'b0;
    valid_in = 1'b1; data_in = 32'h00000055; strb = 4'b0001;
    #1;
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_ready: got %b, expected 0", ready_out);
    end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || bytes_sent !== 16'd19 || ready_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_after: got v=%b b=%b cnt=%0d r=%b, expected 0 0 19 1",
               valid_out, busy, bytes_sent, ready_out);
    end
    ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h55 || last !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_next_word: got v=%b d=%h l=%b, expected 1 55 1",
               valid_out, data_out, last);
    end
    tick();
    n_checks++;
    if (bytes_sent !== 16'd20) begin
      n_fail++;
      $display("[TB] FAIL flush_count: got %0d, expected 20", bytes_sent);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    ready4_in = 1'b1;
    for (int w = 0; w < 5; w++) begin
      valid4_in = 1'b1; data4_in = 32'h12345678; strb4 = (w < 4) ? 4'hF : 4'h1;
      tick();
      valid4_in = 1'b0;
      for (int b = 0; b < ((w < 4) ? 4 : 1); b++) tick();
      if (w == 3) begin
        n_checks++;
        if (bytes4 !== 4'd0) begin
          n_fail++;
          $display("[TB] FAIL wrap_16: got %0d, expected 0", bytes4);
        end
      end
    end
    n_checks++;
    if (bytes4 !== 4'd1 || valid4_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrap_17: got cnt=%0d v=%b, expected 1 0", bytes4, valid4_out);
    end
  endtask

  task automatic test_reset_midword();
    valid_in = 1'b1; data_in = 32'hE4E3E2E1; strb = 4'hF; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid_out, data_out, last, busy, bytes_sent, ready_out} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_midword: got v=%b d=%h l=%b b=%b cnt=%0d r=%b, expected 0 00 0 0 0 1",
               valid_out, data_out, last, busy, bytes_sent, ready_out);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_residue: got v=%b b=%b, expected 0 0", valid_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_sparse_and_zero();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
